// File: rtl/digit_scanner_pkg.sv
// Shared constants and cell-decode helpers for the score/time digit overlay.
// Geometry is fixed at 10x10 px cells; fields are whole multiples of a cell.
package digit_scanner_pkg;

    localparam logic [9:0] CELL_PX       = 10'd10;
    localparam logic [7:0] CELL_PIXELS   = 8'd100;
    localparam logic [3:0] BLANK_DIGIT   = 4'd10;
    localparam logic [9:0] SCORE_FIELD_W = 10'd30;
    localparam logic [9:0] TIME_FIELD_W  = 10'd50;
    localparam logic [2:0] CELL_NONE     = 3'd7;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] off;
    } cell_pos_t;

    // Compare chain against multiples of the cell width instead of a divider.
    function automatic cell_pos_t cell_split(input logic [9:0] rel);
        cell_pos_t  pos;
        logic [9:0] tmp;
        tmp = 10'd0;
        pos = '{idx: CELL_NONE, off: 4'd0};
        if (rel < CELL_PX) begin
            pos.idx = 3'd0;
            tmp     = rel;
        end else if (rel < 10'd20) begin
            pos.idx = 3'd1;
            tmp     = rel - 10'd10;
        end else if (rel < 10'd30) begin
            pos.idx = 3'd2;
            tmp     = rel - 10'd20;
        end else if (rel < 10'd40) begin
            pos.idx = 3'd3;
            tmp     = rel - 10'd30;
        end else if (rel < 10'd50) begin
            pos.idx = 3'd4;
            tmp     = rel - 10'd40;
        end else begin
            pos.idx = CELL_NONE;
            tmp     = 10'd0;
        end
        pos.off = tmp[3:0];
        return pos;
    endfunction

    function automatic logic [7:0] pixel_index(input logic [3:0] dy, input logic [3:0] dx);
        logic [7:0] idx;
        idx = ({4'd0, dy} * 8'd10) + {4'd0, dx};
        return (idx < CELL_PIXELS) ? idx : 8'd0;
    endfunction

endpackage

// File: rtl/digit_scanner_bcd_digit.sv
// One BCD digit counter wrapping at MAX; carry is combinational so digits chain in one cycle.
module bcd_digit
    import digit_scanner_pkg::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock_25,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic       carry,
    output logic [3:0] value
);

    logic [3:0] value_r;

    // Digit register: clear has priority over increment.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            value_r <= 4'd0;
        end else if (clr) begin
            value_r <= 4'd0;
        end else if (inc) begin
            if (value_r == MAX) begin
                value_r <= 4'd0;
            end else begin
                value_r <= value_r + 4'd1;
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign carry = inc && !clr && (value_r == MAX);
    assign value = value_r;

endmodule

// File: rtl/digit_scanner.sv
// Score and mm:ss timer keeper feeding the numbers glyph ROM; selected_number leads
// number_count by one cycle because the ROM registers the digit but not the pixel index.
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter logic [9:0] SCORE_X = 10'd20,
    parameter logic [9:0] SCORE_Y = 10'd10,
    parameter logic [9:0] TIME_X  = 10'd560,
    parameter logic [9:0] TIME_Y  = 10'd10,
    parameter int         CLK_HZ  = 25_000_000
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        game_run,
    input  logic        game_clear,
    input  logic        apple_eaten,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [3:0]  selected_number,
    output logic [7:0]  number_count,
    output logic        digit_active,
    output logic [11:0] score_bcd,
    output logic [15:0] time_bcd
);

    localparam int                PRE_W    = $clog2(CLK_HZ + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic             score_sat_s;
    logic             time_sat_s;
    logic             score_inc_s;
    logic             su_carry_s, st_carry_s, sh_carry_s;
    logic             tsu_carry_s, tst_carry_s, tmu_carry_s, tmt_carry_s;
    logic [3:0]       su_s, st_s, sh_s;
    logic [3:0]       tsu_s, tst_s, tmu_s, tmt_s;
    logic [11:0]      score_bcd_s;
    logic [15:0]      time_bcd_s;

    assign score_bcd_s = {sh_s, st_s, su_s};
    assign time_bcd_s  = {tmt_s, tmu_s, tst_s, tsu_s};
    assign score_sat_s = (score_bcd_s == 12'h999);
    assign time_sat_s  = (time_bcd_s == 16'h9959);
    assign score_inc_s = apple_eaten && !score_sat_s;
    assign tick_s      = game_run && !time_sat_s && (pre_r == PRE_LAST);

    // Seconds prescaler: frozen while paused or once the timer has saturated.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            pre_r <= '0;
        end else if (game_clear) begin
            pre_r <= '0;
        end else if (game_run && !time_sat_s) begin
            if (pre_r == PRE_LAST) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end else begin
            pre_r <= pre_r;
        end
    end

    bcd_digit #(.MAX(4'd9)) u_score_units (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(score_inc_s), .carry(su_carry_s), .value(su_s));
    bcd_digit #(.MAX(4'd9)) u_score_tens (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(su_carry_s), .carry(st_carry_s), .value(st_s));
    bcd_digit #(.MAX(4'd9)) u_score_hundreds (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(st_carry_s), .carry(sh_carry_s), .value(sh_s));

    bcd_digit #(.MAX(4'd9)) u_sec_units (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(tick_s), .carry(tsu_carry_s), .value(tsu_s));
    bcd_digit #(.MAX(4'd5)) u_sec_tens (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(tsu_carry_s), .carry(tst_carry_s), .value(tst_s));
    bcd_digit #(.MAX(4'd9)) u_min_units (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(tst_carry_s), .carry(tmu_carry_s), .value(tmu_s));
    bcd_digit #(.MAX(4'd9)) u_min_tens (
        .clock_25(clock_25), .reset_n(reset_n), .clr(game_clear),
        .inc(tmu_carry_s), .carry(tmt_carry_s), .value(tmt_s));

    logic [9:0] rel_score_s, rel_time_s, dy_score_s, dy_time_s;
    logic       in_score_s, in_time_s;
    cell_pos_t  score_pos_s, time_pos_s;
    logic [3:0] digit_s, dx_s, dy_s;
    logic       active_s;

    // Coordinate decode; the score field wins if the two fields are ever placed overlapping.
    always_comb begin
        rel_score_s = x - SCORE_X;
        rel_time_s  = x - TIME_X;
        dy_score_s  = y - SCORE_Y;
        dy_time_s   = y - TIME_Y;
        in_score_s  = (x >= SCORE_X) && (rel_score_s < SCORE_FIELD_W)
                   && (y >= SCORE_Y) && (dy_score_s < CELL_PX);
        in_time_s   = (x >= TIME_X) && (rel_time_s < TIME_FIELD_W)
                   && (y >= TIME_Y) && (dy_time_s < CELL_PX);
        score_pos_s = cell_split(rel_score_s);
        time_pos_s  = cell_split(rel_time_s);
        digit_s     = BLANK_DIGIT;
        dx_s        = 4'd0;
        dy_s        = 4'd0;
        active_s    = 1'b0;
        if (in_score_s) begin
            active_s = 1'b1;
            dx_s     = score_pos_s.off;
            dy_s     = dy_score_s[3:0];
            case (score_pos_s.idx)
                3'd0:    digit_s = sh_s;
                3'd1:    digit_s = st_s;
                3'd2:    digit_s = su_s;
                default: digit_s = BLANK_DIGIT;
            endcase
        end else if (in_time_s) begin
            active_s = 1'b1;
            dx_s     = time_pos_s.off;
            dy_s     = dy_time_s[3:0];
            case (time_pos_s.idx)
                3'd0:    digit_s = tmt_s;
                3'd1:    digit_s = tmu_s;
                3'd3:    digit_s = tst_s;
                3'd4:    digit_s = tsu_s;
                default: digit_s = BLANK_DIGIT;
            endcase
        end else begin
            active_s = 1'b0;
        end
    end

    logic [3:0] sel_r, dx_r, dy_r;
    logic       active_r;
    logic [7:0] number_count_r;
    logic       digit_active_r;

    // Two-stage skew: digit at t+1, pixel index and active flag at t+2.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            sel_r          <= BLANK_DIGIT;
            dx_r           <= 4'd0;
            dy_r           <= 4'd0;
            active_r       <= 1'b0;
            number_count_r <= 8'd0;
            digit_active_r <= 1'b0;
        end else begin
            sel_r          <= digit_s;
            dx_r           <= dx_s;
            dy_r           <= dy_s;
            active_r       <= active_s;
            number_count_r <= pixel_index(dy_r, dx_r);
            digit_active_r <= active_r;
        end
    end

    assign selected_number = sel_r;
    assign number_count    = number_count_r;
    assign digit_active    = digit_active_r;
    assign score_bcd       = score_bcd_s;
    assign time_bcd        = time_bcd_s;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed self-checking bench for digit_scanner with a 10-cycle second.
module tb_digit_scanner;

    localparam logic [9:0] SX = 10'd20;
    localparam logic [9:0] SY = 10'd10;
    localparam logic [9:0] TX = 10'd560;
    localparam logic [9:0] TY = 10'd10;

    logic        clock_25 = 1'b0;
    logic        reset_n = 1'b0;
    logic        game_run = 1'b0;
    logic        game_clear = 1'b0;
    logic        apple_eaten = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic [3:0]  selected_number;
    logic [7:0]  number_count;
    logic        digit_active;
    logic [11:0] score_bcd;
    logic [15:0] time_bcd;

    int total_checks = 0;
    int pass_checks  = 0;

    digit_scanner #(
        .SCORE_X(SX), .SCORE_Y(SY), .TIME_X(TX), .TIME_Y(TY), .CLK_HZ(10)
    ) dut (
        .clock_25(clock_25), .reset_n(reset_n), .game_run(game_run),
        .game_clear(game_clear), .apple_eaten(apple_eaten), .x(x), .y(y),
        .selected_number(selected_number), .number_count(number_count),
        .digit_active(digit_active), .score_bcd(score_bcd), .time_bcd(time_bcd)
    );

    always #20 clock_25 = ~clock_25;

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock_25);
        total_checks++;
        if (selected_number !== 4'd10) $display("FAIL reset_sel: got %0d expected 10", selected_number);
        else pass_checks++;
        total_checks++;
        if (number_count !== 8'd0 || digit_active !== 1'b0)
            $display("FAIL reset_nc: got nc=%0d act=%0b expected 0/0", number_count, digit_active);
        else pass_checks++;
        total_checks++;
        if (score_bcd !== 12'h000 || time_bcd !== 16'h0000)
            $display("FAIL reset_cnt: got score=%h time=%h expected 000/0000", score_bcd, time_bcd);
        else pass_checks++;
        reset_n = 1'b1;
    endtask

    task automatic test_first_pixel;
        x = SX + 10'd3;
        y = SY + 10'd2;
        @(negedge clock_25);
        total_checks++;
        if (selected_number !== 4'd0) $display("FAIL first_sel: got %0d expected 0", selected_number);
        else pass_checks++;
        x = 10'd0;
        y = 10'd0;
        @(negedge clock_25);
        total_checks++;
        if (number_count !== 8'd23 || digit_active !== 1'b1)
            $display("FAIL first_nc: got nc=%0d act=%0b expected 23/1", number_count, digit_active);
        else pass_checks++;
    endtask

    task automatic pulse_apple;
        apple_eaten = 1'b1;
        @(negedge clock_25);
        apple_eaten = 1'b0;
        @(negedge clock_25);
    endtask

    task automatic test_score;
        repeat (7) pulse_apple();
        total_checks++;
        if (score_bcd !== 12'h007) $display("FAIL score_7: got %h expected 007", score_bcd);
        else pass_checks++;
        x = SX + 10'd15;
        y = SY;
        @(negedge clock_25);
        total_checks++;
        if (selected_number !== 4'd0) $display("FAIL score_tens_cell: got %0d expected 0", selected_number);
        else pass_checks++;
        x = SX + 10'd25;
        @(negedge clock_25);
        total_checks++;
        if (selected_number !== 4'd7) $display("FAIL score_units_cell: got %0d expected 7", selected_number);
        else pass_checks++;
        apple_eaten = 1'b1;
        repeat (992) @(negedge clock_25);
        apple_eaten = 1'b0;
        total_checks++;
        if (score_bcd !== 12'h999) $display("FAIL score_999: got %h expected 999", score_bcd);
        else pass_checks++;
        pulse_apple();
        total_checks++;
        if (score_bcd !== 12'h999) $display("FAIL score_sat: got %h expected 999", score_bcd);
        else pass_checks++;
        x = SX + 10'd5;
        @(negedge clock_25);
        total_checks++;
        if (selected_number !== 4'd9) $display("FAIL score_hund_cell: got %0d expected 9", selected_number);
        else pass_checks++;
        x = 10'd0;
        y = 10'd0;
    endtask

    task automatic test_timer;
        game_clear = 1'b1;
        @(negedge clock_25);
        game_clear = 1'b0;
        total_checks++;
        if (score_bcd !== 12'h000) $display("FAIL clear_score: got %h expected 000", score_bcd);
        else pass_checks++;
        game_run = 1'b1;
        repeat (600) @(negedge clock_25);
        game_run = 1'b0;
        total_checks++;
        if (time_bcd !== 16'h0100) $display("FAIL timer_600: got %h expected 0100", time_bcd);
        else pass_checks++;
        repeat (5) @(negedge clock_25);
        total_checks++;
        if (time_bcd !== 16'h0100) $display("FAIL timer_pause: got %h expected 0100", time_bcd);
        else pass_checks++;
        game_run = 1'b1;
        repeat (10) @(negedge clock_25);
        game_run = 1'b0;
        total_checks++;
        if (time_bcd !== 16'h0101) $display("FAIL timer_resume: got %h expected 0101", time_bcd);
        else pass_checks++;
        game_run = 1'b1;
        repeat (59380) @(negedge clock_25);
        total_checks++;
        if (time_bcd !== 16'h9959) $display("FAIL timer_9959: got %h expected 9959", time_bcd);
        else pass_checks++;
        repeat (50) @(negedge clock_25);
        game_run = 1'b0;
        total_checks++;
        if (time_bcd !== 16'h9959) $display("FAIL timer_sat: got %h expected 9959", time_bcd);
        else pass_checks++;
    endtask

    task automatic test_simultaneous;
        game_clear = 1'b1;
        @(negedge clock_25);
        game_clear = 1'b0;
        repeat (3) pulse_apple();
        game_run = 1'b1;
        repeat (9) @(negedge clock_25);
        game_clear  = 1'b1;
        apple_eaten = 1'b1;
        @(negedge clock_25);
        game_clear  = 1'b0;
        apple_eaten = 1'b0;
        game_run    = 1'b0;
        total_checks++;
        if (score_bcd !== 12'h000 || time_bcd !== 16'h0000)
            $display("FAIL clear_wins: got score=%h time=%h expected 000/0000", score_bcd, time_bcd);
        else pass_checks++;
        game_run = 1'b1;
        repeat (9) @(negedge clock_25);
        apple_eaten = 1'b1;
        @(negedge clock_25);
        apple_eaten = 1'b0;
        game_run    = 1'b0;
        total_checks++;
        if (score_bcd !== 12'h001 || time_bcd !== 16'h0001)
            $display("FAIL apple_and_tick: got score=%h time=%h expected 001/0001", score_bcd, time_bcd);
        else pass_checks++;
    endtask

    task automatic test_field_scan;
        logic [3:0] digits [5];
        logic [3:0] exp_sel;
        logic [7:0] exp_nc;
        logic       exp_act;
        int         prev;
        digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd10; digits[3] = 4'd3; digits[4] = 4'd4;
        game_run = 1'b1;
        repeat (7530) @(negedge clock_25);
        game_run = 1'b0;
        total_checks++;
        if (time_bcd !== 16'h1234) $display("FAIL timer_1234: got %h expected 1234", time_bcd);
        else pass_checks++;
        y = TY + 10'd3;
        for (int i = 0; i <= 52; i++) begin
            if (i <= 51) x = TX + 10'(i);
            @(negedge clock_25);
            if (i <= 51) begin
                exp_sel = (i < 50) ? digits[i / 10] : 4'd10;
                total_checks++;
                if (selected_number !== exp_sel)
                    $display("FAIL scan_sel[%0d]: got %0d expected %0d", i, selected_number, exp_sel);
                else pass_checks++;
            end
            prev = i - 1;
            if (prev >= 0) begin
                exp_act = (prev < 50);
                exp_nc  = exp_act ? 8'(30 + (prev % 10)) : 8'd0;
                total_checks++;
                if (number_count !== exp_nc || digit_active !== exp_act)
                    $display("FAIL scan_nc[%0d]: got nc=%0d act=%0b expected %0d/%0b",
                             prev, number_count, digit_active, exp_nc, exp_act);
                else pass_checks++;
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clock_25);
        test_first_pixel();
        test_score();
        test_timer();
        test_simultaneous();
        test_field_scan();
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
# digit_scanner

Upstream feeder for the `numbers` glyph ROM in the time-and-score overlay. It keeps the game's BCD score and mm:ss play timer. From the VGA pixel coordinates it decides which digit cell, if any, is being drawn. It then issues `selected_number` and `number_count` with the one-cycle skew the glyph ROM needs, because that ROM registers the digit but indexes the pixel combinationally.

## Interface
Parameters:
- `SCORE_X`, default 10'd20: left pixel column of the 3-digit score field.
- `SCORE_Y`, default 10'd10: top pixel row of the score field.
- `TIME_X`, default 10'd560: left pixel column of the time field (mm, one blank cell, ss).
- `TIME_Y`, default 10'd10: top pixel row of the time field.
- `CLK_HZ`, default 25_000_000: clock cycles per timer second.

Ports:
- `clock_25` in 1: the only clock, 25 MHz pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `game_run` in 1: the timer advances while this is high.
- `game_clear` in 1: synchronous clear of score, time and prescaler.
- `apple_eaten` in 1: one-cycle pulse that adds 1 to the score.
- `x` in 10: current pixel column.
- `y` in 10: current pixel row.
- `selected_number` out 4: digit 0–9, or 10 for blank.
- `number_count` out 8: pixel index 0–99 inside the cell.
- `digit_active` out 1: the current pixel lies inside a digit cell.
- `score_bcd` out 12: score as three BCD digits (hundreds, tens, units).
- `time_bcd` out 16: time as mm and ss, BCD.

## Operation
- **Geometry**
  - Cells are 10×10 px.
  - The score field is 30×10 px at (`SCORE_X`, `SCORE_Y`) and shows hundreds, tens, units.
  - The time field is 50×10 px at (`TIME_X`, `TIME_Y`), with cells in this order: m-tens, m-units, blank, s-tens, s-units.
  - Within a cell, with dx = x − cell_left and dy = y − cell_top, `number_count` = dy·10 + dx, range 0..99.
  - No divider is used: the cell index comes from a compare chain against multiples of 10.
- **Blank cell and outside pixels**
  - The blank time cell drives `selected_number`=10, `digit_active`=1 and `number_count` as computed.
  - A pixel outside both fields drives `selected_number`=10, `number_count`=0 and `digit_active`=0.
- **Score**
  - A 3-digit BCD counter increments on `apple_eaten`.
  - It saturates at 999; further pulses are ignored.
- **Timer**
  - A prescaler counts 0..`CLK_HZ`−1 while `game_run`=1 and holds its value while `game_run`=0.
  - It wraps to 0 and raises a one-cycle tick.
  - Each tick adds one second: ss wraps 59→00 and carries into mm.
  - Time saturates at 99:59. Once saturated, the prescaler stops and no further ticks occur.
- **Simultaneous events**
  - `game_clear` overrides `apple_eaten` and tick arriving in the same cycle.
  - `apple_eaten` and a tick in the same cycle both take effect.
- **Reset values:** all counters, `score_bcd`, `time_bcd` and `number_count` reset to 0; `selected_number` resets to 10; `digit_active` resets to 0.

## Timing
- Coordinate pipeline:
  - Cycle t: `x` and `y` are sampled.
  - Cycle t+1: registered `selected_number` is valid for that pixel.
  - Cycle t+2: registered `number_count` and `digit_active` are valid for that pixel.
  - `numbers` registers `selected_number` at t+2, so its `number_pixel` is correct during t+2.
- Counter outputs:
  - `score_bcd` updates one cycle after `apple_eaten`.
  - `time_bcd` updates one cycle after the tick.
  - The displayed digits follow from the next sampled coordinate onward. A mid-frame update may cause a one-frame tear, which is accepted.
- Reset mid-frame: outputs go to reset values immediately. Outputs are valid again for pixels sampled from the first clock after `reset_n` rises.

## Structure
- Shared package constants: `CELL_PX`=10, `CELL_PIXELS`=100, `BLANK_DIGIT`=4'd10, and the field widths (30 and 50).
- Sub-module `bcd_digit`: a single BCD digit with parameter `MAX` (9 or 5), inputs `inc` and `clr`, and outputs `carry` and `value`.
  - The 3 score digits are instances of it.
  - The 4 time digits are instances of it.
  - Saturation logic stays in `digit_scanner`.
- Everything else stays in `digit_scanner`: prescaler, coordinate decode and the 2-stage output pipeline.

## Test plan
- **Reset and first pixel:** reset, then drive x=SCORE_X+3, y=SCORE_Y+2 → at t+1 `selected_number`=0; at t+2 `number_count`=23 and `digit_active`=1.
- **Score count and saturation:** 7 `apple_eaten` pulses → `score_bcd`=12'h007 and tens cell shows 0. From 999, one more pulse → still 12'h999.
- **Timer with CLK_HZ=10:** hold `game_run`=1 for 600 cycles → `time_bcd`=16'h0100.
  - Drop `game_run` for 5 cycles → no change.
  - Preload to 99:59 → stays 99:59.
- **Clear versus simultaneous events:** `game_clear` together with `apple_eaten` and a tick → score and time both 0.
  - `apple_eaten` together with a tick → both increment.
- **Field scan:** sweep the time-field row at time 12:34 → `selected_number` sequence 1,2,10,3,4, each held for 10 px.
  - `number_count` lags `selected_number` by one cycle.
  - Pixel TIME_X+50 → `digit_active`=0 and `selected_number`=10.
